fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage driving the IF->IF/ID interface (pc_plus4, instr) of the 5-stage core.
//  Owns the PC, issues in-order requests to instruction memory over a valid/ready channel,
//  buffers returned words with their PC+4 in a small FIFO, and presents them to IF/ID.
//  Handles ID-stage stall and branch/jump redirect (flush + discard of in-flight responses).
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset release
//  FIFO_DEPTH  2              fetch-buffer entries (power of 2, >=2); also max in-flight requests
// PORTS
//  clk             in   1   clock, all state on rising edge
//  reset           in   1   asynchronous, active-low reset (0 = reset)
//  imem_req_valid  out  1   request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word-aligned fetch address (= PC)
//  imem_rsp_valid  in   1   response word valid; responses return in request order, >=1 cycle later
//  imem_rsp_data   in   32  instruction word
//  stall           in   1   ID cannot accept; hold output
//  redirect_valid  in   1   taken branch/jump; flush and refetch
//  redirect_pc     in   32  new PC (bits [1:0] ignored, forced 0)
//  if_valid        out  1   if_pc_plus4/if_instr hold a valid fetched instruction
//  if_pc_plus4     out  32  PC+4 of presented instruction
//  if_instr        out  32  presented instruction
//  fetch_count     out  32  [FETCH_PERF_EN only] accepted instructions
//  bubble_count    out  32  [FETCH_PERF_EN only] cycles with !stall && !if_valid
// BEHAVIOUR
//  Reset (reset=0, async): pc=RESET_PC, FIFO empty, inflight=0, drop=0, state=BOOT;
//   imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc_plus4=0, if_instr=0, perf counters=0.
//  FSM: BOOT -> RUN unconditionally (one idle cycle after reset release).
//   RUN: imem_req_valid=1 iff inflight+fifo_count < FIFO_DEPTH. Accept = valid&&ready:
//     pc<=pc+4, push pc+4 into tag queue, inflight++.
//   RUN + redirect_valid: pc<=redirect_pc, FIFO flushed, drop<=inflight' (in-flight after this
//     cycle, counting a request accepted and excluding a response returned this cycle);
//     next state DRAIN if drop'>0 else RUN. imem_req_valid forced 0 in redirect cycle.
//   DRAIN: imem_req_valid=0; each rsp decrements drop and inflight, data discarded;
//     drop reaching 0 -> RUN next cycle. redirect_valid in DRAIN: pc updated, stay DRAIN.
//  Response in RUN (not dropped): push {tag_queue_head, rsp_data} into FIFO, inflight--.
//   Never overflows: issue limit guarantees space. rsp_valid with inflight==0 is illegal (assert).
//  Output: if_valid = FIFO non-empty; if_pc_plus4/if_instr = FIFO head, driven from registers;
//   0 when empty. Pop when if_valid && !stall. Push and pop same cycle allowed (count unchanged).
//  Latency: request accept -> earliest if_valid = rsp latency + 1 cycle (rsp registered into FIFO).
//  Priority: reset > redirect > stall. redirect with stall=1 still flushes (held word is wrong-path).
//  Redirect same cycle as pop: pop ignored, flush wins.
//  PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently; if_pc_plus4 of 32'hFFFF_FFFC is 0.
//  Reset asserted mid-operation: all state cleared immediately; memory side must also reset.
// CONFIGURATION
//  FETCH_PERF_EN defined: fetch_count (+1 per pop) and bubble_count (+1 per cycle !stall&&!if_valid)
//   ports exist, 32-bit, wrap at 2^32, cleared by reset only.
//  FETCH_PERF_EN undefined: both ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset release, mem ready=1, 1-cycle rsp, stall=0 -> addrs 0,4,8..; if_pc_plus4 4,8,12 in order, no gaps after fill.
//  2 Stall=1 for 5 cycles with FIFO full -> imem_req_valid=0, outputs held stable; release -> resume in order.
//  3 Redirect to 32'h100 with 2 requests in flight -> DRAIN, 2 rsps discarded, next if_pc_plus4=32'h104.
//  4 Redirect and request-accept same cycle, rsp 3-cycle latency -> accepted req dropped, no wrong-path if_valid.
//  5 Assert reset=0 mid-stream with FIFO holding 2 -> if_valid=0, outputs 0 same cycle; refetch from RESET_PC.
//  6 FETCH_PERF_EN: 10 pops + 3 empty unstalled cycles -> fetch_count=10, bubble_count=3 (incl. BOOT cycle).

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the 5-stage core.
//   - Owns the PC and issues in-order word fetches to instruction memory over
//     a valid/ready request channel. Responses come back in request order,
//     at least one cycle after the request was accepted.
//   - Tags every outstanding request with its PC+4 in a small tag queue.
//   - Buffers returned words together with their PC+4 in a FIFO and presents
//     the FIFO head to IF/ID.
//   - Handles ID-stage stall (hold the presented word) and branch/jump
//     redirect (flush the buffer, discard responses still in flight, refetch).
//
// Parameters
//   RESET_PC    first PC fetched after reset release
//   FIFO_DEPTH  fetch-buffer entries (power of 2, >= 2); also the maximum
//               number of requests in flight
//
// Optional feature (compile-time macro FETCH_PERF_EN)
//   When defined, adds the fetch_count and bubble_count performance counter
//   ports. When undefined, both ports and counters are absent and all other
//   behaviour is identical.
//
// Ports
//   clk             in   1   clock, all state on rising edge
//   reset           in   1   asynchronous, active-low reset (0 = reset)
//   imem_req_valid  out  1   request valid
//   imem_req_ready  in   1   memory accepts request this cycle
//   imem_req_addr   out  32  word-aligned fetch address (= PC)
//   imem_rsp_valid  in   1   response word valid (in request order)
//   imem_rsp_data   in   32  instruction word
//   stall           in   1   ID cannot accept; hold output
//   redirect_valid  in   1   taken branch/jump; flush and refetch
//   redirect_pc     in   32  new PC (bits [1:0] ignored)
//   if_valid        out  1   if_pc_plus4/if_instr hold a fetched instruction
//   if_pc_plus4     out  32  PC+4 of presented instruction (0 when empty)
//   if_instr        out  32  presented instruction (0 when empty)
//   fetch_count     out  32  [FETCH_PERF_EN] instructions accepted by ID
//   bubble_count    out  32  [FETCH_PERF_EN] cycles with !stall && !if_valid
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    // Pointer width for the tag queue and fetch buffer, and a counter width
    // wide enough to hold the value FIFO_DEPTH itself.
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic [31:0]   redirect_target;

    // Tag queue: PC+4 of each outstanding request, oldest at tag_rd.
    logic [31:0]   tag_q [FIFO_DEPTH];
    logic [AW-1:0] tag_wr;
    logic [AW-1:0] tag_rd;

    // Fetch buffer: returned words with their PC+4, head at buf_rd.
    logic [31:0]   buf_pc4   [FIFO_DEPTH];
    logic [31:0]   buf_instr [FIFO_DEPTH];
    logic [AW-1:0] buf_wr;
    logic [AW-1:0] buf_rd;
    logic [CW-1:0] buf_count;

    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] drop;
    logic [CW-1:0] drop_next;
    logic [CW:0]   occupancy;

    logic          accept;
    logic          flush;
    logic          push;
    logic          pop;

    // Redirect targets are forced word-aligned.
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4        = pc + 32'd4;
    assign imem_req_addr   = pc;

    // Issue limit counts both buffered words and requests still in flight,
    // so every outstanding response is guaranteed a buffer slot.
    assign occupancy = {1'b0, inflight} + {1'b0, buf_count};

    assign accept = imem_req_valid && imem_req_ready;
    assign flush  = (state == RUN) && redirect_valid;

    // A response is kept only in RUN; in DRAIN (and in a flush cycle) it is
    // wrong-path and discarded. Flush also overrides a pop.
    assign push = imem_rsp_valid && (state == RUN) && !redirect_valid;
    assign pop  = if_valid && !stall && !flush;

    // Outstanding-request bookkeeping for the end of this cycle. On a flush
    // every request still in flight after this cycle becomes a drop.
    always_comb begin
        inflight_next = inflight + CW'(accept) - CW'(imem_rsp_valid);
        drop_next     = drop;
        if (flush) begin
            drop_next = inflight_next;
        end else if ((state == DRAIN) && imem_rsp_valid) begin
            drop_next = drop - CW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic. BOOT gives one idle cycle after reset release.
    // A redirect during DRAIN only moves the PC; draining continues until
    // the last discarded response has returned.
    always_comb begin
        state_next = state;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    state_next = (inflight_next != '0) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                state_next = (drop_next == '0) ? RUN : DRAIN;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // FSM outputs. Requests only in RUN, never in a redirect cycle, and only
    // while the buffer plus in-flight requests leave room. The IF/ID side
    // reads the buffer head straight from its registers, zero when empty.
    always_comb begin
        imem_req_valid = 1'b0;
        if ((state == RUN) && !redirect_valid && (occupancy < DEPTH_LIMIT)) begin
            imem_req_valid = 1'b1;
        end
        if_valid    = (buf_count != '0);
        if_pc_plus4 = '0;
        if_instr    = '0;
        if (if_valid) begin
            if_pc_plus4 = buf_pc4[buf_rd];
            if_instr    = buf_instr[buf_rd];
        end
    end

    // PC, tag pointers and in-flight/drop counters. Any redirect moves the
    // PC; the tag queue pops on every response, kept or discarded, so it
    // stays aligned with the memory's in-order response stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            tag_wr   <= '0;
            tag_rd   <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_target;
            end else if (accept) begin
                pc <= pc_plus4;
            end
            if (accept) begin
                tag_wr <= tag_wr + AW'(1);
            end
            if (imem_rsp_valid) begin
                tag_rd <= tag_rd + AW'(1);
            end
            inflight <= inflight_next;
            drop     <= drop_next;
        end
    end

    // Tag storage holds data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q[tag_wr] <= pc_plus4;
        end
    end

    // Fetch-buffer control. A flush empties the buffer and wins over any
    // push or pop in the same cycle; push and pop together leave the count
    // unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
        end else if (flush) begin
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
        end else begin
            if (push) begin
                buf_wr <= buf_wr + AW'(1);
            end
            if (pop) begin
                buf_rd <= buf_rd + AW'(1);
            end
            buf_count <= buf_count + CW'(push) - CW'(pop);
        end
    end

    // Fetch-buffer storage: pairs the returned word with the PC+4 tag of
    // the oldest outstanding request.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc4[buf_wr]   <= tag_q[tag_rd];
            buf_instr[buf_wr] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: instructions handed to ID and unstalled empty
    // cycles (the BOOT cycle counts as a bubble). Both wrap freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (pop) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (!stall && !if_valid) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

    // A response with nothing outstanding means the memory side is broken,
    // and a push into a full buffer would mean the issue limit failed.
    rsp_needs_inflight: assert property (
        @(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (inflight != '0)
    );

    push_has_space: assert property (
        @(posedge clk) disable iff (!reset)
        push |-> ({1'b0, buf_count} < DEPTH_LIMIT)
    );

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Testbench for fetch_unit: randomized memory timing, stall and redirect
// traffic checked against a stream-level reference model with a scoreboard.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .bubble_count   (bubble_count)
`endif
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory model: in-order responses with per-request random latency.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t pend[$];
    int    mem_cycle = 0;
    int    lat_min   = 1;
    int    lat_max   = 1;
    int    ready_pct = 100;

    initial begin
        mreq_t r;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (reset && imem_req_valid && imem_req_ready) begin
                r.addr = imem_req_addr;
                r.due  = mem_cycle + $urandom_range(lat_max, lat_min);
                pend.push_back(r);
            end
            @(posedge clk);
            #1;
            mem_cycle++;
            if (!reset) pend.delete();
            if (pend.size() > 0 && pend[0].due <= mem_cycle) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            imem_req_ready = ($urandom_range(99, 0) < ready_pct);
        end
    end

    // ------------------------------------------------------------------
    // Reference model + scoreboard. The model tracks the expected fetch
    // stream: sequential PCs from the last reset/redirect target, every
    // accepted request expecting {pc+4, word(pc)} in order, everything
    // outstanding discarded by a redirect.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] model_pc   = RESET_PC;
    int          inflight_m = 0;
    int          drop_m     = 0;
    int          buffered_m = 0;
    bit          boot_m     = 1'b1;
    int          pops       = 0;
    logic [31:0] fetch_m    = '0;
    logic [31:0] bubble_m   = '0;

    initial begin
        exp_t e;
        bit   acc;
        bit   rsp;
        bit   exp_req;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
                checkOutput("rst_if_pc_plus4", if_pc_plus4, 32'd0);
                checkOutput("rst_if_instr", if_instr, 32'd0);
                checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
                checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
`ifdef FETCH_PERF_EN
                checkOutput("rst_fetch_count", fetch_count, 32'd0);
                checkOutput("rst_bubble_count", bubble_count, 32'd0);
`endif
                expq.delete();
                model_pc   = RESET_PC;
                inflight_m = 0;
                drop_m     = 0;
                buffered_m = 0;
                boot_m     = 1'b1;
                fetch_m    = '0;
                bubble_m   = '0;
            end else begin
                acc     = imem_req_valid && imem_req_ready;
                rsp     = imem_rsp_valid;
                exp_req = !boot_m && (drop_m == 0) && !redirect_valid &&
                          (inflight_m + buffered_m < FIFO_DEPTH);
                checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req));
                checkOutput("if_valid", 32'(if_valid), 32'(buffered_m > 0));
                if (if_valid) begin
                    checkOutput("scoreboard_has_entry", 32'(expq.size() > 0), 32'd1);
                    if (expq.size() > 0) begin
                        checkOutput("if_pc_plus4", if_pc_plus4, expq[0].pc4);
                        checkOutput("if_instr", if_instr, expq[0].instr);
                    end
                end else begin
                    checkOutput("idle_pc_plus4", if_pc_plus4, 32'd0);
                    checkOutput("idle_instr", if_instr, 32'd0);
                end
`ifdef FETCH_PERF_EN
                checkOutput("fetch_count", fetch_count, fetch_m);
                checkOutput("bubble_count", bubble_count, bubble_m);
`endif
                if (!stall && !if_valid) bubble_m = bubble_m + 32'd1;
                if (redirect_valid) begin
                    inflight_m = inflight_m - int'(rsp);
                    drop_m     = inflight_m;
                    buffered_m = 0;
                    expq.delete();
                    model_pc   = redirect_pc & 32'hFFFF_FFFC;
                end else begin
                    if (acc) begin
                        checkOutput("req_addr", imem_req_addr, model_pc);
                        e.pc4   = model_pc + 32'd4;
                        e.instr = word_of(model_pc);
                        expq.push_back(e);
                        model_pc = model_pc + 32'd4;
                        checkOutput("outstanding_limit", 32'(expq.size() <= FIFO_DEPTH), 32'd1);
                    end
                    if (rsp && drop_m > 0) drop_m--;
                    else if (rsp) buffered_m++;
                    if (if_valid && !stall) begin
                        if (expq.size() > 0) void'(expq.pop_front());
                        if (buffered_m > 0) buffered_m--;
                        pops++;
                        fetch_m = fetch_m + 32'd1;
                    end
                    inflight_m = inflight_m + int'(acc) - int'(rsp);
                end
                boot_m = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic applyStimulus(input bit stall_v, input bit redir_v,
                                 input logic [31:0] redir_pc_v);
        @(posedge clk);
        #1;
        stall          = stall_v;
        redirect_valid = redir_v;
        redirect_pc    = redir_pc_v;
    endtask

    task automatic doReset();
        @(posedge clk);
        #3;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        checkOutput("async_rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("async_rst_if_pc_plus4", if_pc_plus4, 32'd0);
        checkOutput("async_rst_if_instr", if_instr, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    // Waits (bounded) for the next presented instruction and checks its PC+4.
    task automatic waitValid(input string name, input logic [31:0] pc4_exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (if_valid) begin
                seen = 1'b1;
                checkOutput(name, if_pc_plus4, pc4_exp);
            end
        end
        checkOutput({name, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic redirectWithInflight(input logic [31:0] target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #2;
            if (inflight_m == FIFO_DEPTH) found = 1'b1;
        end
        checkOutput("inflight_full_seen", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] rp;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;

        // Straight-line fetch, always-ready memory, 1-cycle responses.
        $display("[TB] phase: sequential fetch");
        ready_pct = 100; lat_min = 1; lat_max = 1;
        repeat (30) applyStimulus(1'b0, 1'b0, '0);

        // Stall with the buffer full: no requests, head held.
        $display("[TB] phase: stall");
        repeat (5) applyStimulus(1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("stall_buffer_full", 32'(if_valid), 32'd1);
        repeat (20) applyStimulus(1'b0, 1'b0, '0);

        // Redirect with two requests in flight (3-cycle latency).
        $display("[TB] phase: redirect drain");
        lat_min = 3; lat_max = 3;
        redirectWithInflight(32'h0000_0100);
        waitValid("redirect_first_pc4", 32'h0000_0104);
        repeat (10) applyStimulus(1'b0, 1'b0, '0);

        // Redirect near the top of the address space: PC wraps to 0.
        $display("[TB] phase: pc wrap");
        redirectWithInflight(32'hFFFF_FFFB);
        waitValid("wrap_first_pc4", 32'hFFFF_FFFC);
        waitValid("wrap_second_pc4", 32'h0000_0000);
        repeat (10) applyStimulus(1'b0, 1'b0, '0);

        // Reset mid-stream with the buffer holding words.
        $display("[TB] phase: mid-stream reset");
        lat_min = 1; lat_max = 1;
        repeat (6) applyStimulus(1'b1, 1'b0, '0);
        doReset();
        waitValid("post_reset_first_pc4", RESET_PC + 32'd4);

        // Randomized traffic.
        $display("[TB] phase: random");
        ready_pct = 75; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                doReset();
            end else begin
                case ($urandom_range(3, 0))
                    0:       rp = $urandom;
                    1:       rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                    2:       rp = $urandom_range(255, 0);
                    default: rp = 32'h0000_1000 + ($urandom & 32'hFF);
                endcase
                applyStimulus($urandom_range(3, 0) == 0, $urandom_range(24, 0) == 0, rp);
            end
        end
        applyStimulus(1'b0, 1'b0, '0);
        repeat (10) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("pop_activity", 32'(pops > 200), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
